fir_inverse: RTL



---
 rtl/fir_pkg.sv | 17 +
 rtl/sat_narrow.sv | 20 ++
 rtl/fir_inverse.sv | 109 ++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared filter package: default widths, history state enum, saturation helper.
package fir_pkg;
   localparam int DW_DEF   = 16;
   localparam int CW_DEF   = 16;
   localparam int ACCW_DEF = DW_DEF + CW_DEF + 2;

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   // Clip a default-width accumulator to a default-width sample.
   function automatic logic signed [DW_DEF-1:0] sat_dw(input logic signed [ACCW_DEF-1:0] a);
      logic [ACCW_DEF-DW_DEF:0] hi;
      hi = a[ACCW_DEF-1:DW_DEF-1];
      if ((&hi) || !(|hi)) return a[DW_DEF-1:0];
      else if (a[ACCW_DEF-1]) return {1'b1, {(DW_DEF-1){1'b0}}};
      else return {1'b0, {(DW_DEF-1){1'b1}}};
   endfunction
endpackage

// File: rtl/sat_narrow.sv
// Signed saturation from IW to OW bits with an overflow indication.
module sat_narrow #(
   parameter int IW = 34,
   parameter int OW = 16
) (
   input  logic signed [IW-1:0] a,
   output logic signed [OW-1:0] y,
   output logic                 ovf
);
   logic [IW-OW:0] hi;

   // In range when every bit above the output sign bit matches it.
   always_comb begin
      hi  = a[IW-1:OW-1];
      ovf = !((&hi) || !(|hi));
      if (!ovf)          y = a[OW-1:0];
      else if (a[IW-1])  y = {1'b1, {(OW-1){1'b0}}};
      else               y = {1'b0, {(OW-1){1'b1}}};
   end
endmodule

// File: rtl/fir_inverse.sv
// Recursive inverse of the 3-tap FIR (h0 = 1): x[n] = y[n] - H1*x[n-1] - H2*x[n-2].
module fir_inverse
   import fir_pkg::*;
#(
   parameter int                     DW = DW_DEF,
   parameter int                     CW = CW_DEF,
   parameter logic signed [CW-1:0]   H1 = 16'sd2,
   parameter logic signed [CW-1:0]   H2 = 16'sd3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic signed [DW-1:0] y_in,
   input  logic                 y_valid,
   output logic signed [DW-1:0] x_out,
   output logic                 x_valid,
   output logic                 ovf,
   output logic [15:0]          sample_cnt,
   output logic                 primed
);
   localparam int ACCW = DW + CW + 2;

   logic signed [DW-1:0]   x1_q, x1_d, x2_q, x2_d, x_out_q, x_out_d;
   logic                   x_valid_q, x_valid_d, ovf_q, ovf_d;
   logic [15:0]            cnt_q, cnt_d;
   state_t                 state_q, state_d;
   logic signed [DW-1:0]   hx1, hx2, sat_val;
   logic signed [ACCW-1:0] acc;
   logic                   sat_ovf;

   // Accumulator; a clear in the same cycle makes the sample see zero history.
   always_comb begin
      hx1 = clear ? '0 : x1_q;
      hx2 = clear ? '0 : x2_q;
      acc = ACCW'(y_in) - ACCW'(H1) * ACCW'(hx1) - ACCW'(H2) * ACCW'(hx2);
   end

   sat_narrow #(.IW(ACCW), .OW(DW)) u_sat (
      .a   (acc),
      .y   (sat_val),
      .ovf (sat_ovf)
   );

   // Datapath next state: shift history on valid samples, otherwise hold.
   always_comb begin
      x1_d      = x1_q;
      x2_d      = x2_q;
      x_out_d   = x_out_q;
      x_valid_d = 1'b0;
      ovf_d     = ovf_q;
      cnt_d     = cnt_q;
      if (y_valid) begin
         x_out_d   = sat_val;
         x_valid_d = 1'b1;
         x1_d      = sat_val;
         x2_d      = hx1;
         ovf_d     = ovf_q | sat_ovf;
         cnt_d     = (clear ? 16'd0 : cnt_q) + 16'd1;
      end else if (clear) begin
         x1_d  = '0;
         x2_d  = '0;
         cnt_d = 16'd0;
      end
   end

   // History-depth FSM next state; counts valid samples since reset or clear.
   always_comb begin
      state_d = state_q;
      if (clear) state_d = y_valid ? ONE : EMPTY;
      else if (y_valid) begin
         case (state_q)
            EMPTY:   state_d = ONE;
            ONE:     state_d = FULL;
            default: state_d = FULL;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= EMPTY;
      else     state_q <= state_d;
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x1_q      <= '0;
         x2_q      <= '0;
         x_out_q   <= '0;
         x_valid_q <= 1'b0;
         ovf_q     <= 1'b0;
         cnt_q     <= 16'd0;
      end else begin
         x1_q      <= x1_d;
         x2_q      <= x2_d;
         x_out_q   <= x_out_d;
         x_valid_q <= x_valid_d;
         ovf_q     <= ovf_d;
         cnt_q     <= cnt_d;
      end
   end

   assign x_out      = x_out_q;
   assign x_valid    = x_valid_q;
   assign ovf        = ovf_q;
   assign sample_cnt = cnt_q;
   assign primed     = (state_q == FULL);
endmodule
